// File: rtl/mat_tile_engine_if.sv
// Handshake bundle between the tile engine, the command controller and the
// DRAM cache read/write ports. The engine connects through the slave modport.
interface mat_tile_engine_if #(
  parameter int ELEM_W   = 32,
  parameter int TILE_DIM = 4,
  parameter int ADDR_W   = 28
);
  localparam int DATA_WIDTH = ELEM_W * TILE_DIM * TILE_DIM;

  logic                  start;
  logic [1:0]            mode;
  logic [ADDR_W-1:0]     base_a;
  logic [ADDR_W-1:0]     base_b;
  logic [ADDR_W-1:0]     base_res;
  logic [ADDR_W-1:0]     num_words;
  logic                  busy;
  logic                  done;
  logic                  rd_req_valid;
  logic                  rd_req_ready;
  logic [ADDR_W-1:0]     rd_addr_a;
  logic [ADDR_W-1:0]     rd_addr_b;
  logic                  rd_data_valid;
  logic                  rd_data_ready;
  logic [DATA_WIDTH-1:0] data_A;
  logic [DATA_WIDTH-1:0] data_B;
  logic                  wr_valid;
  logic                  wr_ready;
  logic [ADDR_W-1:0]     wr_addr;
  logic [DATA_WIDTH-1:0] data_res;

  modport master (
    output start, mode, base_a, base_b, base_res, num_words,
    output rd_req_ready, rd_data_valid, data_A, data_B, wr_ready,
    input  busy, done, rd_req_valid, rd_addr_a, rd_addr_b,
    input  rd_data_ready, wr_valid, wr_addr, data_res
  );

  modport slave (
    input  start, mode, base_a, base_b, base_res, num_words,
    input  rd_req_ready, rd_data_valid, data_A, data_B, wr_ready,
    output busy, done, rd_req_valid, rd_addr_a, rd_addr_b,
    output rd_data_ready, wr_valid, wr_addr, data_res
  );
endinterface

// File: rtl/mat_tile_engine.sv
// Streaming tile engine: paired A/B tile reads, per-element combine
// (add/sub/hadamard/matmul) and in-order result writes over num_words words.
module mat_tile_lane #(
  parameter int ELEM_W   = 32,
  parameter int TILE_DIM = 4
) (
  input  logic [1:0]                       i_mode,
  input  logic [ELEM_W-1:0]                i_a,
  input  logic [ELEM_W-1:0]                i_b,
  input  logic [TILE_DIM-1:0][ELEM_W-1:0]  i_a_row,
  input  logic [TILE_DIM-1:0][ELEM_W-1:0]  i_b_col,
  output logic [ELEM_W-1:0]                o_res
);
  logic [ELEM_W-1:0] w_dot;

  always_comb begin
    w_dot = '0;
    for (int k = 0; k < TILE_DIM; k++) w_dot = w_dot + i_a_row[k] * i_b_col[k];
  end

  always_comb begin
    o_res = '0;
    unique case (i_mode)
      2'd0: o_res = i_a + i_b;
      2'd1: o_res = i_a - i_b;
      2'd2: o_res = i_a * i_b;
      2'd3: o_res = w_dot;
      default: o_res = '0;
    endcase
  end
endmodule

module mat_tile_engine #(
  parameter int ELEM_W          = 32,
  parameter int TILE_DIM        = 4,
  parameter int ADDR_W          = 28,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic             clk,
  input  logic             reset,
  mat_tile_engine_if.slave bus
);
  localparam int DATA_WIDTH = ELEM_W * TILE_DIM * TILE_DIM;
  localparam int NUM_LANES  = TILE_DIM * TILE_DIM;
  localparam int C_W        = ADDR_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                r_state, w_next;
  logic [1:0]            r_mode;
  logic [ADDR_W-1:0]     r_base_a, r_base_b, r_base_res, r_num;
  logic [C_W-1:0]        r_req_cnt, r_ret_cnt, r_wr_cnt;
  logic                  r_wr_valid;
  logic [DATA_WIDTH-1:0] r_data_res;

  logic w_busy, w_done, w_req_valid, w_data_ready;
  logic w_req_hs, w_data_hs, w_wr_hs, w_last_wr;
  logic [NUM_LANES-1:0][ELEM_W-1:0] w_res;

  assign w_req_hs  = w_req_valid && bus.rd_req_ready;
  assign w_data_hs = bus.rd_data_valid && w_data_ready;
  assign w_wr_hs   = r_wr_valid && bus.wr_ready;
  assign w_last_wr = w_wr_hs && ((r_wr_cnt + C_W'(1)) == {1'b0, r_num});

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Request gating uses registered counters, so simultaneous request and
  // return handshakes are only seen by the outstanding check next cycle.
  always_comb begin
    w_next       = r_state;
    w_busy       = 1'b1;
    w_done       = 1'b0;
    w_req_valid  = 1'b0;
    w_data_ready = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_busy = 1'b0;
        if (bus.start) w_next = (bus.num_words == '0) ? S_DONE : S_RUN;
      end
      S_RUN: begin
        w_req_valid  = (r_req_cnt < {1'b0, r_num}) &&
                       ((r_req_cnt - r_ret_cnt) < C_W'(MAX_OUTSTANDING));
        w_data_ready = !r_wr_valid || bus.wr_ready;
        if (w_last_wr) w_next = S_DONE;
      end
      S_DONE: begin
        w_done = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mode     <= '0;
      r_base_a   <= '0;
      r_base_b   <= '0;
      r_base_res <= '0;
      r_num      <= '0;
      r_req_cnt  <= '0;
      r_ret_cnt  <= '0;
      r_wr_cnt   <= '0;
      r_wr_valid <= 1'b0;
      r_data_res <= '0;
    end else begin
      if (r_state == S_IDLE && bus.start) begin
        r_mode     <= bus.mode;
        r_base_a   <= bus.base_a;
        r_base_b   <= bus.base_b;
        r_base_res <= bus.base_res;
        r_num      <= bus.num_words;
        r_req_cnt  <= '0;
        r_ret_cnt  <= '0;
        r_wr_cnt   <= '0;
      end else begin
        if (w_req_hs)  r_req_cnt <= r_req_cnt + C_W'(1);
        if (w_data_hs) r_ret_cnt <= r_ret_cnt + C_W'(1);
        if (w_wr_hs)   r_wr_cnt  <= r_wr_cnt + C_W'(1);
      end
      // A fresh result overrides the clear from a same-cycle write handshake.
      if (w_data_hs) begin
        r_wr_valid <= 1'b1;
        r_data_res <= w_res;
      end else if (w_wr_hs) begin
        r_wr_valid <= 1'b0;
      end
    end
  end

  for (genvar gi = 0; gi < TILE_DIM; gi++) begin : g_row
    for (genvar gj = 0; gj < TILE_DIM; gj++) begin : g_col
      logic [TILE_DIM-1:0][ELEM_W-1:0] w_a_row, w_b_col;
      for (genvar gk = 0; gk < TILE_DIM; gk++) begin : g_k
        assign w_a_row[gk] = bus.data_A[(gi*TILE_DIM+gk)*ELEM_W +: ELEM_W];
        assign w_b_col[gk] = bus.data_B[(gk*TILE_DIM+gj)*ELEM_W +: ELEM_W];
      end
      mat_tile_lane #(.ELEM_W(ELEM_W), .TILE_DIM(TILE_DIM)) u_lane (
        .i_mode  (r_mode),
        .i_a     (w_a_row[gj]),
        .i_b     (w_b_col[gi]),
        .i_a_row (w_a_row),
        .i_b_col (w_b_col),
        .o_res   (w_res[gi*TILE_DIM+gj])
      );
    end
  end

  assign bus.busy          = w_busy;
  assign bus.done          = w_done;
  assign bus.rd_req_valid  = w_req_valid;
  assign bus.rd_addr_a     = r_base_a + r_req_cnt[ADDR_W-1:0];
  assign bus.rd_addr_b     = r_base_b + r_req_cnt[ADDR_W-1:0];
  assign bus.rd_data_ready = w_data_ready;
  assign bus.wr_valid      = r_wr_valid;
  assign bus.wr_addr       = r_base_res + r_wr_cnt[ADDR_W-1:0];
  assign bus.data_res      = r_data_res;
endmodule

// File: doc/mat_tile_engine.md
# mat_tile_engine

Parametrised streaming tile engine for the DRAM cache matrix path. It runs one command over `num_words` consecutive DRAM words. Each word holds a TILE_DIM×TILE_DIM tile of ELEM_W-bit elements. For every word the engine issues paired A/B read requests, combines the returned tiles in one of four modes (add, subtract, element-wise multiply, tile matrix multiply), and writes the result tiles in order to a result region. It sits between the DRAM cache read/write ports and the command controller, with valid/ready handshakes on every side.

## Interface
- `ELEM_W`, 32, element width in bits
- `TILE_DIM`, 4, tile rows = tile columns
- `DATA_WIDTH`, ELEM_W*TILE_DIM*TILE_DIM (512), DRAM word width; derived, not overridden
- `ADDR_W`, 28, word-address width
- `MAX_OUTSTANDING`, 8, maximum read requests issued but not yet returned (≥1)

Ports:
- `clk`  in  1  single clock; all logic on the rising edge
- `reset`  in  1  asynchronous, active-low reset
- `start`  in  1  command strobe; sampled only in IDLE
- `mode`  in  2  0=ADD, 1=SUB, 2=HADAMARD, 3=MATMUL; latched on start
- `base_a`, `base_b`, `base_res`  in  ADDR_W  region base word addresses; latched on start
- `num_words`  in  ADDR_W  words to process; latched on start
- `busy`  out  1  high whenever state ≠ IDLE
- `done`  out  1  one-cycle pulse at command completion
- `rd_req_valid`  out  1 / `rd_req_ready`  in  1  read-request handshake
- `rd_addr_a`, `rd_addr_b`  out  ADDR_W  base_a+req_cnt, base_b+req_cnt, mod 2^ADDR_W
- `rd_data_valid`  in  1 / `rd_data_ready`  out  1  read-data handshake; data returns in request order
- `data_A`, `data_B`  in  DATA_WIDTH  returned tiles
- `wr_valid`  out  1 / `wr_ready`  in  1  result-write handshake
- `wr_addr`  out  ADDR_W  base_res+wr_cnt, mod 2^ADDR_W
- `data_res`  out  DATA_WIDTH  result tile

## Operation
- Tile layout: element (i,j) sits at bits [(i*TILE_DIM+j)*ELEM_W +: ELEM_W]. Row-major, row 0 in the LSBs. The same layout applies to `data_A`, `data_B` and `data_res`.
- Arithmetic is unsigned and modulo 2^ELEM_W; all overflow is discarded.
  - ADD: A+B.
  - SUB: A−B.
  - HADAMARD: low ELEM_W bits of A[i][j]*B[i][j].
  - MATMUL: R[i][j] = Σk A[i][k]*B[k][j], truncated to ELEM_W bits.
- State machine IDLE → RUN → DONE → IDLE:
  - IDLE + `start`: latch mode, bases and num_words, and clear req_cnt, ret_cnt and wr_cnt. Go to DONE if num_words=0, otherwise to RUN.
  - RUN: go to DONE on the cycle whose write handshake makes wr_cnt = num_words.
  - DONE: `done`=1 for one cycle, then IDLE.
- `start` outside IDLE is ignored, and so are mode/base/num_words changes during a command.
- Read-request rules:
  - `rd_req_valid` = RUN && req_cnt < num_words && (req_cnt − ret_cnt) < MAX_OUTSTANDING.
  - req_cnt increments on each request handshake.
  - Once asserted, `rd_req_valid` and the addresses hold until `rd_req_ready`.
- Data rules:
  - `rd_data_ready` = RUN && (!wr_valid || wr_ready).
  - On a data handshake the result is computed and registered into `data_res`, `wr_valid` is set, and ret_cnt increments.
- Write rules:
  - wr_cnt increments on each write handshake.
  - `wr_valid` clears on a write handshake unless a new result loads in the same cycle.
  - `data_res` and `wr_addr` are stable while `wr_valid && !wr_ready`.
- `rd_data_valid` outside RUN is not accepted.
- Counters are ADDR_W+1 bits wide. Address sums wrap at 2^ADDR_W with no error.

## Timing
- Reset (asynchronous assert): state=IDLE; all counters and latched fields are 0. `busy`, `done`, `rd_req_valid`, `rd_data_ready` and `wr_valid` are 0, and `data_res`=0. Reset mid-command aborts it with no `done`.
- `start` in cycle T: `busy`=1 and `rd_req_valid` may assert from T+1.
- Latency: data handshake at cycle T gives `wr_valid`=1 at T+1.
- Throughput: one word per cycle when `rd_req_ready`, `rd_data_valid` and `wr_ready` are held high.
- Final write handshake at T: `done`=1 at T+1, `busy`=0 at T+2.
- num_words=0 with `start` at T: `done`=1 at T+1 and no requests are issued.
- Request and data handshakes in the same cycle update req_cnt and ret_cnt together; the outstanding check uses the registered values.

## Test plan
- ADD, num_words=1, every A element 5, every B element 7 → one write of all elements 12 at `wr_addr`=base_res, then a single `done` pulse.
- SUB with A=0, B=1, plus ADD with A=0xFFFFFFFF, B=2 → elements 0xFFFFFFFF and 0x00000001 respectively.
- MATMUL:
  - B=identity → `data_res`=A.
  - A all 2, B all 3 → every element 24.
  - HADAMARD with 0x10000 × 0x10000 → 0.
- num_words=4, `wr_ready` low for 5 cycles mid-run → `rd_data_ready` low while stalled and `data_res` held stable. The four results arrive in order at base_res+0..3; `done` follows the last handshake by one cycle.
- `rd_req_ready`=1, `rd_data_valid`=0, num_words=20 → exactly 8 requests (addresses base_a+0..7), then `rd_req_valid` stays low until data returns.
- num_words=0 → `done` at T+1 and no `rd_req_valid`. Separately, reset asserted mid-RUN → all outputs 0 immediately and no `done`.
